// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM-state definitions for the ALU op sequencer.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Any opcode with the top bit set is illegal and never reaches the ALU.
    function automatic logic op_is_legal(input logic [2:0] op);
        return !op[2];
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one op at a time through an external combinational ALU; optional accumulator under ALU_SEQ_ACC_EN.
// Latency: legal op 3 edges, illegal op 1 edge to rsp_valid; req_ready only in IDLE, response held until rsp_ready.
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
`ifdef ALU_SEQ_ACC_EN
    input  logic             req_use_acc,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);

    import alu_seq_pkg::*;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_op_count;
    logic             w_accept;
    logic             w_rsp_fire;
    logic             w_legal;
    logic [WIDTH-1:0] w_opa;

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] r_acc;
    assign w_opa = req_use_acc ? r_acc : req_a;
`else
    assign w_opa = req_a;
`endif

    assign w_accept   = req_valid & req_ready;
    assign w_rsp_fire = rsp_valid & rsp_ready;
    assign w_legal    = op_is_legal(req_op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_legal ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE:   w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_RESP;
            ST_RESP: begin
                if (w_rsp_fire) begin
                    w_next = ST_IDLE;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    // Gating req_ready with rst_n keeps it low for the whole reset pulse even though the FSM already sits in IDLE.
    always_comb begin
        req_ready = (r_state == ST_IDLE) & rst_n;
        rsp_valid = (r_state == ST_RESP);
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = '0;
        if (r_state == ST_ISSUE || r_state == ST_CAPTURE) begin
            alu_a    = r_a;
            alu_b    = r_b;
            alu_ctrl = r_op;
        end
    end

    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;
    assign op_count   = r_op_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_legal) begin
                        r_a  <= w_opa;
                        r_b  <= req_b;
                        r_op <= req_op;
                    end else if (w_accept) begin
                        r_rsp_result <= '0;
                        r_rsp_zero   <= 1'b1;
                        r_rsp_err    <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    r_rsp_result <= alu_result;
                    r_rsp_zero   <= alu_zero;
                    r_rsp_err    <= 1'b0;
                end
                ST_RESP: begin
                    if (w_rsp_fire) begin
                        r_op_count <= r_op_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_rsp_err <= r_rsp_err;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_ACC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_rsp_fire && !r_rsp_err) begin
            r_acc <= r_rsp_result;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the alu_* port pair.
module tb_alu_op_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = 3'b000;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic             req_use_acc = 1'b0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_err;
    logic [CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a & alu_b;
            3'b010:  alu_result = alu_a | alu_b;
            3'b011:  alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
`ifdef ALU_SEQ_ACC_EN
        .req_use_acc(req_use_acc),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .op_count   (op_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request/response; hold = cycles rsp_ready stays low with a competing request pending.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_acc, input logic [31:0] exp_a,
                          input logic [31:0] exp_res, input logic exp_zero, input logic exp_err,
                          input int hold);
        chk({tag, ".req_ready_idle"}, 64'(req_ready), 64'd1);
        req_op = op; req_a = a; req_b = b; req_use_acc = use_acc; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; req_a = 32'hA5A5_A5A5; req_b = 32'h5A5A_5A5A; req_op = 3'b010; req_use_acc = 1'b0;
        chk({tag, ".req_ready_busy"}, 64'(req_ready), 64'd0);
        if (!exp_err) begin
            chk({tag, ".issue_vld"}, 64'(rsp_valid), 64'd0);
            chk({tag, ".issue_ctrl"}, 64'(alu_ctrl), 64'(op));
            chk({tag, ".issue_a"}, 64'(alu_a), 64'(exp_a));
            chk({tag, ".issue_b"}, 64'(alu_b), 64'(b));
            tick();
            chk({tag, ".cap_vld"}, 64'(rsp_valid), 64'd0);
            chk({tag, ".cap_ctrl"}, 64'(alu_ctrl), 64'(op));
            chk({tag, ".cap_a"}, 64'(alu_a), 64'(exp_a));
            tick();
        end else begin
            chk({tag, ".alu_a_idle"}, 64'(alu_a), 64'd0);
            chk({tag, ".alu_b_idle"}, 64'(alu_b), 64'd0);
            chk({tag, ".alu_ctrl_idle"}, 64'(alu_ctrl), 64'd0);
        end
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".rsp_result"}, 64'(rsp_result), 64'(exp_res));
        chk({tag, ".rsp_zero"}, 64'(rsp_zero), 64'(exp_zero));
        chk({tag, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_op = 3'b000; req_a = 32'd1; req_b = 32'd1;
            tick();
            chk({tag, ".hold_vld"}, 64'(rsp_valid), 64'd1);
            chk({tag, ".hold_result"}, 64'(rsp_result), 64'(exp_res));
            chk({tag, ".hold_rdy"}, 64'(req_ready), 64'd0);
            chk({tag, ".hold_cnt"}, 64'(op_count), 64'(exp_cnt));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 4;
        chk({tag, ".op_count"}, 64'(op_count), 64'(exp_cnt));
        chk({tag, ".rsp_valid_done"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".alu_a_done"}, 64'(alu_a), 64'd0);
    endtask

    initial begin
        #2;
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.op_count", 64'(op_count), 64'd0);
        chk("rst.alu_a", 64'(alu_a), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;

        run_op("xor_same", 3'b011, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0, 0);
        run_op("add_5_7", 3'b000, 32'd5, 32'd7, 1'b0, 32'd5, 32'd12, 1'b0, 1'b0, 0);
        run_op("illegal", 3'b101, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 0);
        run_op("and_hold", 3'b001, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 32'h0000_FF00, 32'h0000_0F00, 1'b0, 1'b0, 5);
        run_op("add_1_1", 3'b000, 32'd1, 32'd1, 1'b0, 32'd1, 32'd2, 1'b0, 1'b0, 0);

        // Abort an op in CAPTURE with an async reset.
        req_op = 3'b000; req_a = 32'd8; req_b = 32'd8; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mid.cap_ctrl_a", 64'(alu_a), 64'd8);
        rst_n = 1'b0;
        #1;
        chk("mid.req_ready", 64'(req_ready), 64'd0);
        chk("mid.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid.rsp_result", 64'(rsp_result), 64'd0);
        chk("mid.rsp_zero", 64'(rsp_zero), 64'd0);
        chk("mid.rsp_err", 64'(rsp_err), 64'd0);
        chk("mid.alu_a", 64'(alu_a), 64'd0);
        chk("mid.alu_b", 64'(alu_b), 64'd0);
        chk("mid.op_count", 64'(op_count), 64'd0);
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        #1;
        run_op("or_after_rst", 3'b010, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0, 0);

`ifdef ALU_SEQ_ACC_EN
        run_op("acc_add_3_4", 3'b000, 32'd3, 32'd4, 1'b0, 32'd3, 32'd7, 1'b0, 1'b0, 0);
        run_op("acc_use", 3'b000, 32'd99, 32'd10, 1'b1, 32'd7, 32'd17, 1'b0, 1'b0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
